// File: rtl/serial_link_sched_pkg.sv
// Shared definitions for the serial link scheduler: FSM state encoding and
// helpers for frame length and counter sizing.
package serial_link_sched_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // One start bit followed by the payload bits.
    function automatic int frame_len(input int dw);
        return dw + 1;
    endfunction

    // The counter must hold 0..DW (FLUSH/SHIFT) and 0..GAP-1 (GAP).
    function automatic int cnt_width(input int dw, input int gap);
        int top;
        top = (frame_len(dw) > gap) ? frame_len(dw) : gap;
        return (top > 1) ? $clog2(top) : 1;
    endfunction

endpackage

// File: rtl/serial_link_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after
// the pointer, wrapping cyclically.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] rot_idx [NREQ];

    // rot_idx[k] is the requester examined at priority rank k.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign rot_idx[gi] = IW'((int'(ptr_i) + gi) % NREQ);
    end

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[rot_idx[k]]) begin
                any_o               = 1'b1;
                idx_o               = rot_idx[k];
                gnt_o[rot_idx[k]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_link_sched.sv
// Round-robin scheduler sharing one serial transmitter between NREQ clients;
// sequences flush, load, shift and optional gap slots so frames arrive intact.
module serial_link_sched
    import serial_link_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 8,
    parameter  int GAP  = 0,
    localparam int IW   = $clog2(NREQ),
    localparam int CW   = cnt_width(DW, GAP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               sen,
    output logic [DW-1:0]      Din,
    output logic               busy,
    output logic [IW-1:0]      cur_id,
    output logic               done
);

    localparam logic [CW-1:0] LAST_BIT = CW'(frame_len(DW) - 1);
    localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            sen_q, sen_d;
    logic [DW-1:0]   din_q, din_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   cur_id_q, cur_id_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            take;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        done_d   = 1'b0;
        take     = 1'b0;

        unique case (state_q)
            ST_FLUSH: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: take = en && arb_any;
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    // Receiver shows valid next cycle and ignores its input then.
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                        take    = en && arb_any;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    take    = en && arb_any;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FLUSH;
        endcase

        if (take) begin
            state_d  = ST_LOAD;
            cur_id_d = arb_idx;
            ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end

        // Outputs are registered, so they are derived from the next state.
        sen_d  = take;
        gnt_d  = take ? arb_gnt : '0;
        din_d  = take ? req_data[arb_idx*DW +: DW] : '0;
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            sen_q    <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            cur_id_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            sen_q    <= sen_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
            done_q   <= done_d;
        end
    end

    assign gnt    = gnt_q;
    assign sen    = sen_q;
    assign Din    = din_q;
    assign busy   = busy_q;
    assign cur_id = cur_id_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_link_sched.sv
// Directed bench for serial_link_sched with a behavioural transmitter/receiver
// pair attached to the GAP=0 instance and a second GAP=3 instance.
module tb_serial_link_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;

    logic [NREQ-1:0] gnt,    gnt_g;
    logic            sen,    sen_g;
    logic [DW-1:0]   din,    din_g;
    logic            busy,   busy_g;
    logic [IW-1:0]   cur_id, cur_id_g;
    logic            done,   done_g;

    serial_link_sched #(.NREQ(NREQ), .DW(DW), .GAP(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .gnt(gnt), .sen(sen), .Din(din), .busy(busy), .cur_id(cur_id), .done(done)
    );

    serial_link_sched #(.NREQ(NREQ), .DW(DW), .GAP(3)) u_dut_gap (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .gnt(gnt_g), .sen(sen_g), .Din(din_g), .busy(busy_g), .cur_id(cur_id_g), .done(done_g)
    );

    always #5 clk = ~clk;

    // Transmitter without reset (starts holding garbage) and its receiver.
    logic [DW:0]   tx_q     = 9'h1B5;
    int            rx_cnt   = 0;
    logic [DW-1:0] rx_sh    = '0;
    logic          rx_valid = 1'b0;

    always @(posedge clk) begin
        if (sen) tx_q <= {1'b1, din};
        else     tx_q <= {tx_q[DW-1:0], 1'b0};
        if (rx_valid) begin
            rx_valid <= 1'b0;
            rx_cnt   <= 0;
        end else if (rx_cnt == 0) begin
            if (tx_q[DW]) rx_cnt <= 1;
        end else begin
            rx_sh  <= {rx_sh[DW-2:0], tx_q[DW]};
            if (rx_cnt == DW) rx_valid <= 1'b1;
            rx_cnt <= rx_cnt + 1;
        end
    end

    int sen_cnt = 0, gnt_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (sen)      sen_cnt  <= sen_cnt + 1;
        if (gnt != 0) gnt_cnt  <= gnt_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_load(input string tag, input bit use_gap, input int max_ticks,
                             output int ticks);
        logic s;
        ticks = 0;
        do begin
            tick();
            ticks++;
            s = use_gap ? sen_g : sen;
        end while (!s && ticks < max_ticks);
        check_eq({tag, "_load_seen"}, 32'(s), 32'd1);
        if (s) begin
            if (use_gap)
                $display("load %s: gnt=%b Din=%h cur_id=%0d after %0d cycles",
                         tag, gnt_g, din_g, cur_id_g, ticks);
            else
                $display("load %s: gnt=%b Din=%h cur_id=%0d after %0d cycles",
                         tag, gnt, din, cur_id, ticks);
        end
    endtask

    logic [7:0] t2_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n, acc, lows, s0, g0, d0;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, acc, lows, s0, g0, d0;

        // Reset release, single requester
        req      = 4'b0001;
        req_data = {24'h0, 8'hA5};
        tick();
        tick();
        check_eq("rst_sen",    32'(sen),    0);
        check_eq("rst_gnt",    32'(gnt),    0);
        check_eq("rst_din",    32'(din),    0);
        check_eq("rst_busy",   32'(busy),   0);
        check_eq("rst_cur_id", 32'(cur_id), 0);
        check_eq("rst_done",   32'(done),   0);
        rst = 1'b0;
        wait_load("t1", 1'b0, 20, n);
        check_eq("t1_flush_len", n, 10);
        check_eq("t1_din",  32'(din),  32'hA5);
        check_eq("t1_gnt",  32'(gnt),  32'b0001);
        check_eq("t1_busy", 32'(busy), 1);
        req = '0;
        acc = 0;
        lows = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            acc  += int'(done);
            lows += int'(busy);
        end
        check_eq("t1_no_early_done", acc, 0);
        check_eq("t1_busy_shift", lows, 9);
        tick();
        check_eq("t1_done",     32'(done),     1);
        check_eq("t1_rx_valid", 32'(rx_valid), 1);
        check_eq("t1_rx_data",  32'(rx_sh),    32'hA5);
        check_eq("t1_idle_busy", 32'(busy),    0);

        // All requesters, strict rotation
        reset_pulse();
        req      = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        wait_load("t2_f0", 1'b0, 20, n);
        for (int f = 0; f < 5; f++) begin
            check_eq($sformatf("t2_gnt%0d", f), 32'(gnt), 32'(1 << (f % 4)));
            check_eq($sformatf("t2_din%0d", f), 32'(din), 32'(t2_bytes[f % 4]));
            if (f == 4) break;
            wait_load($sformatf("t2_f%0d", f + 1), 1'b0, 20, n);
            check_eq($sformatf("t2_period%0d", f), n, 10);
            check_eq($sformatf("t2_done%0d", f), 32'(done), 1);
            check_eq($sformatf("t2_rx%0d", f), 32'(rx_sh), 32'(t2_bytes[f % 4]));
        end
        req = '0;

        // GAP=3 instance, requester 2 sends 3C then 7E
        reset_pulse();
        req      = 4'b0100;
        req_data = {8'h00, 8'h3C, 16'h0};
        wait_load("t3_f0", 1'b1, 20, n);
        check_eq("t3_gnt0",    32'(gnt_g),    32'b0100);
        check_eq("t3_din0",    32'(din_g),    32'h3C);
        check_eq("t3_cur_id0", 32'(cur_id_g), 2);
        req_data[23:16] = 8'h7E;
        n = 0;
        lows = 0;
        do begin
            tick();
            n++;
            if (!busy_g) lows++;
            if (n == 10) check_eq("t3_done", 32'(done_g), 1);
        end while (!sen_g && n < 30);
        $display("load t3_f1: gnt=%b Din=%h after %0d cycles", gnt_g, din_g, n);
        check_eq("t3_period",   n,    13);
        check_eq("t3_busy_low", lows, 3);
        check_eq("t3_gnt1",     32'(gnt_g), 32'b0100);
        check_eq("t3_din1",     32'(din_g), 32'h7E);
        req = '0;

        // en dropped mid-frame
        reset_pulse();
        req      = 4'b0010;
        req_data = {16'h0, 8'hC3, 8'h0};
        wait_load("t4", 1'b0, 20, n);
        check_eq("t4_gnt", 32'(gnt), 32'b0010);
        tick();
        tick();
        tick();
        en = 1'b0;
        s0 = sen_cnt;
        for (int i = 4; i <= 10; i++) tick();
        check_eq("t4_done",    32'(done),  1);
        check_eq("t4_rx_data", 32'(rx_sh), 32'hC3);
        check_eq("t4_no_load", 32'(sen),   0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("t4_held_off", sen_cnt - s0, 0);
        en = 1'b1;
        tick();
        $display("load t4_resume: gnt=%b Din=%h", gnt, din);
        check_eq("t4_resume_sen", 32'(sen), 1);
        check_eq("t4_resume_gnt", 32'(gnt), 32'b0010);
        check_eq("t4_resume_din", 32'(din), 32'hC3);
        req = '0;

        // rst mid-frame, pointer returns to 0
        reset_pulse();
        req      = 4'b0010;
        req_data = {16'h0, 8'h96, 8'h69};
        wait_load("t5_pre", 1'b0, 20, n);
        check_eq("t5_pre_gnt", 32'(gnt), 32'b0010);
        for (int i = 0; i < 4; i++) tick();
        d0 = done_cnt;
        g0 = gnt_cnt;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_sen",  32'(sen),  0);
        check_eq("t5_rst_gnt",  32'(gnt),  0);
        check_eq("t5_rst_done", 32'(done), 0);
        check_eq("t5_rst_busy", 32'(busy), 0);
        #1;
        rst = 1'b0;
        req = 4'b0011;
        wait_load("t5_f0", 1'b0, 20, n);
        check_eq("t5_flush_len", n, 10);
        check_eq("t5_no_abort_done", done_cnt - d0, 0);
        check_eq("t5_no_abort_gnt",  gnt_cnt - g0,  0);
        check_eq("t5_gnt0", 32'(gnt), 32'b0001);
        check_eq("t5_din0", 32'(din), 32'h69);
        req = 4'b0010;
        wait_load("t5_f1", 1'b0, 20, n);
        check_eq("t5_period", n, 10);
        check_eq("t5_gnt1", 32'(gnt), 32'b0010);
        check_eq("t5_din1", 32'(din), 32'h96);
        req = '0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t5_done",    32'(done),  1);
        check_eq("t5_rx_data", 32'(rx_sh), 32'h96);

        // Short req pulse while busy is ignored and leaves the pointer alone
        reset_pulse();
        req      = 4'b0001;
        req_data = {16'h0, 8'h77, 8'h11};
        wait_load("t6", 1'b0, 20, n);
        check_eq("t6_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        s0 = sen_cnt;
        g0 = gnt_cnt;
        for (int i = 0; i < 15; i++) tick();
        check_eq("t6_no_sen", sen_cnt - s0, 0);
        check_eq("t6_no_gnt", gnt_cnt - g0, 0);
        req = 4'b0011;
        wait_load("t6_ptr", 1'b0, 5, n);
        check_eq("t6_latency", n, 1);
        check_eq("t6_ptr_gnt", 32'(gnt), 32'b0010);
        check_eq("t6_ptr_din", 32'(din), 32'h77);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_link_sched.md
Name: serial_link_sched

Overview:
- Round-robin scheduler that shares the single 8-bit serial transmitter (sen/Din load port) among NREQ requesters.
- Latches the winner's byte, drives a one-cycle load pulse, then holds the transmitter in shift mode for the full frame.
- Inserts the receiver clear slot so every frame is delivered intact to the serial receiver.
- Sits between client logic and the transmit/receive pair, on the same clock.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, payload width; the frame is 1 start bit + DW data bits, MSB first
- GAP, 0, extra idle cycles inserted after each frame (0..15)

Ports:
- clk  in  1  system clock; everything on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  arbitration enable; low blocks new grants, an in-flight frame completes
- req  in  NREQ  per-requester request level; held until granted
- req_data  in  NREQ*DW  requester i byte at [i*DW +: DW]; stable while req[i]=1
- gnt  out  NREQ  one-hot pulse, one cycle, marks the accepted requester
- sen  out  1  transmitter load strobe
- Din  out  DW  byte presented to the transmitter; 0 when sen=0
- busy  out  1  high from LOAD until the state returns to IDLE
- cur_id  out  $clog2(NREQ)  index of the requester owning the current or last frame
- done  out  1  one-cycle pulse in the cycle the receiver shows its valid flag

Behaviour:
- Reset: all outputs 0, rr pointer=0 (requester 0 highest priority), state FLUSH, counter=0.
- Outputs are registered and reach the reset values immediately on rst.
- States: FLUSH -> IDLE -> LOAD -> SHIFT -> (GAP) -> IDLE or LOAD.
- FLUSH: DW+1 cycles with sen=0, then IDLE.
  - The transmitter has no reset, so this drains any stale frame left in it.
  - A garbage frame at the receiver during FLUSH is accepted and is not flagged.
- IDLE: if en=1 and req!=0, pick the first set req at or after the pointer (cyclic).
  - Capture that req_data into the frame register and go to LOAD.
  - Pointer <= winner+1 mod NREQ.
- LOAD: exactly 1 cycle.
  - sen=1, Din=frame register, gnt[winner]=1, cur_id=winner, busy=1.
- SHIFT: exactly DW+1 cycles, sen=0, Din=0, busy=1. The counter counts 0..DW.
- Frame timing, with LOAD in cycle C0:
  - Transmitter loads at the end of C0.
  - Shifts occur at the ends of C1..C(DW+1).
  - The receiver valid flag is high in C(DW+2); done=1 in that same cycle.
- After the last SHIFT cycle:
  - GAP>0: go to GAP for GAP cycles with busy=0 and sen=0, then IDLE.
  - GAP=0: arbitrate in the last SHIFT cycle. If en and req!=0, the next state is LOAD directly, so the minimum frame period is DW+2 cycles. Otherwise go to IDLE.
  - The receiver clears in C(DW+2) and ignores its input, so a LOAD in that cycle is legal.
- done may coincide with the next frame's LOAD/gnt.
- Requester obligations and edge cases:
  - A requester may drop req before it is granted; no frame is sent and no gnt is issued.
  - After gnt, the requester must drop req or present the next byte in the following cycle.
  - req arriving while busy stays pending and is arbitrated at the next decision point.
- en: sampled only at decision points. en=0 never truncates a frame.
- Single requester: back-to-back frames every DW+2 cycles. All requesters: strict rotation 0,1,2,3,0...
- rst asserted mid-frame:
  - sen drops immediately; no gnt or done is produced for the aborted frame.
  - FLUSH is re-entered and the pointer returns to 0.

Decomposition:
- Shared package holds:
  - State encoding constants: FLUSH, IDLE, LOAD, SHIFT, GAP.
  - Frame length DW+1.
  - Counter width.
- One sub-module, rr_arbiter:
  - Purely combinational.
  - Inputs: req, pointer. Outputs: one-hot grant, index, any.
  - Reused by later multi-client blocks.

Test Plan:
- Reset release with req=0001, data0=8'hA5:
  - No sen for 9 cycles (FLUSH).
  - Then LOAD with Din=A5, gnt=0001.
  - done 10 cycles after LOAD, and receiver output=A5 in that cycle.
- req=1111, data 11/22/33/44, GAP=0:
  - gnt order 0001, 0010, 0100, 1000, 0001.
  - sen pulses exactly 10 cycles apart; receiver sequence 11, 22, 33, 44.
- req[2] held with data 3C plus 7E, GAP=3:
  - Frames every 13 cycles; busy low for 3 cycles between frames.
- en=0 raised 3 cycles into SHIFT:
  - The current frame completes with done.
  - No further sen until en=1, then the pending req is granted the next cycle (IDLE decision).
- rst pulsed in SHIFT cycle 4:
  - sen/gnt/done/busy go to 0 immediately.
  - FLUSH lasts 9 cycles.
  - The requester is re-granted afterwards and its byte is received intact.
- req[1] pulsed 1 cycle while busy, then dropped before the decision point:
  - No gnt, no frame; the pointer is unchanged.
